// File: rtl/aes_pkg.sv
// aes_pkg: shared AES column/state types and the column-major byte index helper
package aes_pkg;
  localparam int NB = 4;
  typedef logic [3:0][7:0] col_t;
  typedef logic [15:0][7:0] state_t;
  function automatic logic [3:0] col_idx(input logic [1:0] c, input logic [1:0] r);
    return 4'(4 * c + r);
  endfunction
endpackage

// File: rtl/mod_state_bank.sv
// mod_state_bank: 16-byte state bank; we writes column d into column sel, resetn clears async, q is the stored state
module mod_state_bank
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       we,
  input  logic [1:0] sel,
  input  col_t       d,
  output state_t     q
);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) q <= '0;
    else if (we) begin
      q[col_idx(sel, 2'd0)] <= d[0];
      q[col_idx(sel, 2'd1)] <= d[1];
      q[col_idx(sel, 2'd2)] <= d[2];
      q[col_idx(sel, 2'd3)] <= d[3];
    end
endmodule

// File: rtl/mod_reg16_4to16.sv
// mod_reg16_4to16: packs columns i (wr_en/wr_full) into ping-pong 16-byte states o (o_valid/rd_en), clear aborts, ovf flags dropped writes
module mod_reg16_4to16
  import aes_pkg::*;
#(
  parameter int NBANK = 2
) (
  input  logic   clk,
  input  logic   resetn,
  input  logic   clear,
  input  logic   wr_en,
  input  col_t   i,
  output logic   wr_full,
  output state_t o,
  output logic   o_valid,
  input  logic   rd_en,
  output logic   ovf
);
  logic [NBANK-1:0] bank_full;
  logic             wb, rb;
  logic [$clog2(NB)-1:0] cc;
  logic             acc, pop;
  state_t           q [NBANK];
  assign wr_full = bank_full[wb];
  assign o_valid = bank_full[rb];
  assign o       = q[rb];
  assign acc     = wr_en && !wr_full && !clear;
  assign pop     = rd_en && o_valid && !clear;
  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    mod_state_bank u_bank (
      .clk    (clk),
      .resetn (resetn),
      .we     (acc && wb == 1'(b)),
      .sel    (cc),
      .d      (i),
      .q      (q[b])
    );
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      bank_full <= '0;
      wb        <= 1'b0;
      rb        <= 1'b0;
      cc        <= '0;
      ovf       <= 1'b0;
    end else if (clear) begin
      bank_full <= '0;
      wb        <= 1'b0;
      rb        <= 1'b0;
      cc        <= '0;
      ovf       <= 1'b0;
    end else begin
      if (acc) begin
        cc <= cc + 1'b1;
        if (cc == 2'd3) begin
          bank_full[wb] <= 1'b1;
          wb            <= ~wb;
        end
      end
      if (pop) begin
        bank_full[rb] <= 1'b0;
        rb            <= ~rb;
      end
      if (wr_en && wr_full) ovf <= 1'b1;
    end
endmodule
